systolic_mvu: RTL and testbench

//  Parametrised weight-stationary systolic matrix-vector unit: y = relu?(x * W), N-wide signed Qm.FRAC_BIT.

---
 rtl/systolic_mvu.sv | 149 ++++++++++++++
 tb/tb_systolic_mvu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mvu.sv
// Weight-stationary systolic matrix-vector unit: y = relu?(x * W) in signed Q(WIDTH-FRAC_BIT).FRAC_BIT.
// Row i of the PE array holds W[i][*] and adds x_i * W[i][j] into the partial sum flowing down column j.
module systolic_mvu #(
    parameter int N        = 6,
    parameter int WIDTH    = 16,
    parameter int FRAC_BIT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [N*WIDTH-1:0]   w_row,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_relu,
    input  logic [N*WIDTH-1:0]   x_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   y_data,
    output logic                 busy
);
    localparam int ACC_W  = 2*WIDTH + $clog2(N);
    localparam int STAGES = N + 1;
    localparam int CW     = $clog2(N);

    localparam logic [ACC_W-1:0]        RND   = ACC_W'(1) << (FRAC_BIT-1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t                            state;
    logic [CW-1:0]                     row_cnt;
    logic                              rdy_en;
    logic [N-1:0][N-1:0][WIDTH-1:0]    weight;
    logic [STAGES:0]                   vld_pipe;
    logic [N:0]                        relu_pipe;
    logic [N-1:0][N-1:0][ACC_W-1:0]    acc_pipe;
    logic [N-1:0][WIDTH-1:0]           res_next;
    logic [N-1:0][WIDTH-1:0]           res_q;
    logic                              stall, adv, w_fire, in_fire, pipe_busy;

    function automatic logic [WIDTH-1:0] rnd_sat(input logic [ACC_W-1:0] a, input logic relu);
        logic signed [ACC_W-1:0] r;
        logic [WIDTH-1:0]        y;
        r = $signed(a + RND) >>> FRAC_BIT;
        if (r > MAX_V)      y = MAX_V[WIDTH-1:0];
        else if (r < MIN_V) y = MIN_V[WIDTH-1:0];
        else                y = r[WIDTH-1:0];
        if (relu && y[WIDTH-1]) y = '0;
        return y;
    endfunction

    assign stall     = out_valid & ~out_ready;
    assign adv       = ~stall;
    assign pipe_busy = |vld_pipe;
    // Reload only once the array is fully drained so no vector sees a mix of old and new weights.
    assign w_ready   = rdy_en & ((state != RUN) | (~pipe_busy & ~out_valid));
    assign in_ready  = (state == RUN) & ~stall & ~w_valid;
    assign w_fire    = w_valid & w_ready;
    assign in_fire   = in_valid & in_ready;
    assign busy      = (state == LOAD) | pipe_busy | out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            row_cnt <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (clr) begin
                state   <= EMPTY;
                row_cnt <= '0;
            end else if (w_fire) begin
                if (row_cnt == CW'(N-1)) begin
                    state   <= RUN;
                    row_cnt <= '0;
                end else begin
                    state   <= LOAD;
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && !clr) weight[row_cnt] <= w_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            relu_pipe <= '0;
            res_q     <= '0;
            out_valid <= 1'b0;
            y_data    <= '0;
        end else if (clr) begin
            vld_pipe  <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], in_fire};
            relu_pipe <= {relu_pipe[N-1:0], in_relu};
            res_q     <= res_next;
            out_valid <= vld_pipe[STAGES];
            if (vld_pipe[STAGES]) y_data <= res_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        // Row i only needs lanes i..N-1 of the vector; earlier lanes are already consumed.
        logic [N-1:i][WIDTH-1:0] xs;

        if (i == 0) begin : g_x
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   xs <= '0;
                else if (adv) xs <= x_data;
            end
        end else begin : g_x
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   xs <= '0;
                else if (adv) xs <= g_row[i-1].xs[N-1:i];
            end
        end

        for (genvar j = 0; j < N; j++) begin : g_col
            logic [ACC_W-1:0]   acc_in;
            logic [2*WIDTH-1:0] prod;

            if (i == 0) begin : g_top
                assign acc_in = '0;
            end else begin : g_mid
                assign acc_in = acc_pipe[i-1][j];
            end

            assign prod = {{WIDTH{xs[i][WIDTH-1]}}, xs[i]} *
                          {{WIDTH{weight[i][j][WIDTH-1]}}, weight[i][j]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   acc_pipe[i][j] <= '0;
                else if (adv) acc_pipe[i][j] <= acc_in + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        assign res_next[j] = rnd_sat(acc_pipe[N-1][j], relu_pipe[N]);
    end
endmodule

// File: tb/tb_systolic_mvu.sv
// Scoreboard bench for systolic_mvu: stimulus pushes reference results, a negedge monitor pops and compares.
module tb_systolic_mvu;
    localparam int N = 6, W = 16, F = 10, NW = N*W;

    logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic          w_valid = 1'b0, in_valid = 1'b0, in_relu = 1'b0, out_ready = 1'b1;
    logic [NW-1:0] w_row = '0, x_data = '0;
    logic          w_ready, in_ready, out_valid, busy;
    logic [NW-1:0] y_data;

    systolic_mvu #(.N(N), .WIDTH(W), .FRAC_BIT(F)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .in_valid(in_valid), .in_ready(in_ready), .in_relu(in_relu), .x_data(x_data),
        .out_valid(out_valid), .out_ready(out_ready), .y_data(y_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int            tests = 0, fails = 0;
    logic [NW-1:0] exp_q[$];
    logic [W-1:0]  wm[N][N];
    logic          stall_prev = 1'b0;
    logic [NW-1:0] y_prev = '0;

    task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer dot products, then round-half-up, saturate, optional ReLU.
    function automatic logic [NW-1:0] model(input logic [NW-1:0] x, input logic relu);
        logic [NW-1:0] y;
        longint        acc, r;
        longint        maxv = (longint'(1) << (W-1)) - 1;
        longint        minv = -(longint'(1) << (W-1));
        y = '0;
        for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int i = 0; i < N; i++)
                acc += longint'($signed(x[i*W +: W])) * longint'($signed(wm[i][j]));
            r = (acc + (longint'(1) << (F-1))) >>> F;
            if (r > maxv) r = maxv;
            if (r < minv) r = minv;
            if (relu && r < 0) r = 0;
            y[j*W +: W] = W'(r);
        end
        return y;
    endfunction

    function automatic logic [NW-1:0] row_of(input int i);
        logic [NW-1:0] r;
        for (int j = 0; j < N; j++) r[j*W +: W] = wm[i][j];
        return r;
    endfunction

    function automatic logic [NW-1:0] rand_vec(input int span);
        logic [NW-1:0] v;
        int            s;
        for (int i = 0; i < N; i++) begin
            s = (span == 0) ? int'($urandom) : int'($urandom_range(0, 2*span)) - span;
            v[i*W +: W] = W'(s);
        end
        return v;
    endfunction

    task automatic set_ident();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) wm[i][j] = (i == j) ? 16'h0400 : 16'h0000;
    endtask

    task automatic set_rand(input int span);
        int s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = (span == 0) ? int'($urandom) : int'($urandom_range(0, 2*span)) - span;
                wm[i][j] = W'(s);
            end
    endtask

    task automatic wait_w_hs(input string name);
        logic got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (w_ready) begin got = 1'b1; break; end
        end
        if (!got) begin tests++; fails++; $display("FAIL %s: w_ready timeout", name); end
        @(posedge clk); #1;
    endtask

    task automatic load_w();
        for (int i = 0; i < N; i++) begin
            w_row   = row_of(i);
            w_valid = 1'b1;
            wait_w_hs("load_w");
        end
        w_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [NW-1:0] x, input logic relu, output int waits);
        logic got = 1'b0;
        in_valid = 1'b1; x_data = x; in_relu = relu; waits = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
            waits++;
        end
        if (got) exp_q.push_back(model(x, relu));
        else begin tests++; fails++; $display("FAIL send: in_ready timeout"); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 500; t++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        check(name, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_y", y_data, y_prev);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out: got %0h expected none", y_data);
                end else check("y_data", y_data, exp_q.pop_front());
            end
            stall_prev <= out_valid && !out_ready;
            y_prev     <= y_data;
        end else stall_prev <= 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            wt, lat, run, allz;
        logic [NW-1:0] x;
        logic [W-1:0]  t1v[N];

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_w_ready", w_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("w_ready_release", w_ready, 0);
        @(negedge clk); check("w_ready_rise", w_ready, 1);
        @(posedge clk); #1;

        // Identity weights and first-result latency
        set_ident(); load_w();
        @(negedge clk);
        check("run_busy", busy, 0);
        check("run_in_ready", in_ready, 1);
        @(posedge clk); #1;
        t1v = '{16'hFB33, 16'h0533, 16'h06CC, 16'hFACC, 16'hFACC, 16'h0000};
        for (int i = 0; i < N; i++) x[i*W +: W] = t1v[i];
        send_vec(x, 1'b0, wt);
        lat = 0;
        for (int c = 1; c < 30; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) begin lat = c; break; end
        end
        check("latency", lat, N+2);
        drain("drain_t1");

        // Dense Q6.10 weights, five back-to-back vectors
        set_rand(8192); load_w();
        allz = 0;
        for (int k = 0; k < 5; k++) begin send_vec(rand_vec(4096), 1'b0, wt); allz += wt; end
        check("b2b_accept", allz, 0);
        run = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) run++;
            else if (run > 0) break;
        end
        check("b2b_out_run", run, 5);
        drain("drain_t2");

        // Rounding and saturation corners
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = '0;
        wm[0][0] = 16'h0200; load_w();
        x = '0; x[W-1:0] = 16'h0001;
        send_vec(x, 1'b0, wt);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 16'h7FFF;
        load_w();
        send_vec({N{16'h7FFF}}, 1'b0, wt);
        send_vec({N{16'h8000}}, 1'b0, wt);
        drain("drain_t3");

        // ReLU travels with its own vector
        set_ident(); load_w();
        x = '0; x[W-1:0] = 16'hFB33;
        send_vec(x, 1'b1, wt);
        send_vec(x, 1'b0, wt);
        drain("drain_t4");

        // Backpressure mid-stream
        set_rand(8192); load_w();
        fork
            begin for (int k = 0; k < 12; k++) send_vec(rand_vec(4096), 1'($urandom_range(0, 1)), wt); end
            begin repeat (10) @(posedge clk); #1 out_ready = 1'b0; repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
        join
        drain("drain_t5");

        // Reload request while vectors are in flight
        for (int k = 0; k < 3; k++) send_vec(rand_vec(4096), 1'b0, wt);
        set_rand(8192);
        w_row = row_of(0); w_valid = 1'b1;
        @(negedge clk);
        check("reload_w_blocked", w_ready, 0);
        check("reload_in_blocked", in_ready, 0);
        check("reload_busy", busy, 1);
        @(posedge clk); #1;
        load_w();
        send_vec(rand_vec(4096), 1'b0, wt);
        send_vec(rand_vec(4096), 1'b1, wt);
        drain("drain_reload");

        // clr aborts a partial load
        for (int i = 0; i < 3; i++) begin w_row = row_of(i); w_valid = 1'b1; wait_w_hs("part_load"); end
        w_valid = 1'b0;
        @(negedge clk); check("load_busy", busy, 1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("clr_load_busy", busy, 0);
        check("clr_load_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // clr mid-stream discards in-flight vectors
        load_w();
        for (int k = 0; k < 3; k++) send_vec(rand_vec(4096), 1'b0, wt);
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("clr_out_valid", out_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_in_ready", in_ready, 0);
        check("clr_w_ready", w_ready, 1);
        repeat (12) @(posedge clk);
        #1;

        // Async reset mid-stream
        load_w();
        for (int k = 0; k < 3; k++) send_vec(rand_vec(4096), 1'b0, wt);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_w_ready", w_ready, 0);
        check("arst_in_ready", in_ready, 0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-range random stream with random gaps and backpressure
        set_rand(0); load_w();
        begin
            logic bp_stop = 1'b0;
            fork
                begin
                    for (int k = 0; k < 40; k++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send_vec(rand_vec(0), 1'($urandom_range(0, 1)), wt);
                    end
                    bp_stop = 1'b1;
                end
                begin
                    while (!bp_stop) begin
                        @(posedge clk); #1;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    out_ready = 1'b1;
                end
            join
        end
        drain("drain_rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
